// File: rtl/fb_pkg.sv
// Shared constants and types for the frame-buffer rectangle fill engine.
package fb_pkg;

  localparam int FB_W = 400;
  localparam int FB_H = 240;
  localparam int AW   = 17;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLIP   = 3'd1,
    VSWAIT = 3'd2,
    FILL   = 3'd3,
    DONE   = 3'd4
  } state_t;

  typedef logic [15:0] rgb565_t;

endpackage

// File: rtl/fb_addr_gen.sv
// Address walker for one rectangle: clips the command to the buffer on load,
// then steps row-major through the clipped area one pixel per advance.
// The row base is y*400 built from shifts and adds, so FB_W is assumed 400.
module fb_addr_gen #(
  parameter int FB_W = fb_pkg::FB_W,
  parameter int FB_H = fb_pkg::FB_H,
  parameter int AW   = fb_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          advance,
  input  logic [8:0]    x,
  input  logic [7:0]    y,
  input  logic [8:0]    w,
  input  logic [7:0]    h,
  output logic [AW-1:0] addr,
  output logic          last
);

  localparam logic [8:0]    W_LIM    = 9'(FB_W);
  localparam logic [7:0]    H_LIM    = 8'(FB_H);
  localparam logic [AW-1:0] ROW_STEP = AW'(FB_W);

  logic [AW-1:0] y_ext;
  logic [AW-1:0] x_ext;
  logic [AW-1:0] base;
  logic [AW-1:0] row_base;
  logic [AW-1:0] x_col;
  logic [8:0]    w_room;
  logic [8:0]    w_eff;
  logic [8:0]    w_load;
  logic [8:0]    col_left;
  logic [7:0]    h_room;
  logic [7:0]    h_eff;
  logic [7:0]    row_left;

  assign y_ext  = AW'(y);
  assign x_ext  = AW'(x);
  assign base   = (y_ext << 8) + (y_ext << 7) + (y_ext << 4);
  assign w_room = W_LIM - x;
  assign h_room = H_LIM - y;
  assign w_eff  = (w > w_room) ? w_room : w;
  assign h_eff  = (h > h_room) ? h_room : h;
  assign last   = (col_left == 9'd1) && (row_left == 8'd1);

  // Load the clipped counters and first address, then walk pixel by pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr     <= '0;
      row_base <= '0;
      x_col    <= '0;
      w_load   <= '0;
      col_left <= '0;
      row_left <= '0;
    end else if (load) begin
      row_base <= base;
      addr     <= base + x_ext;
      x_col    <= x_ext;
      w_load   <= w_eff;
      col_left <= w_eff;
      row_left <= h_eff;
    end else if (advance) begin
      if (col_left == 9'd1) begin
        col_left <= w_load;
        row_left <= row_left - 8'd1;
        row_base <= row_base + ROW_STEP;
        addr     <= row_base + ROW_STEP + x_col;
      end else begin
        col_left <= col_left - 9'd1;
        addr     <= addr + AW'(1);
      end
    end
  end

endmodule

// File: rtl/fb_rect_fill.sv
// Rectangle fill engine: accepts a command, clips it, optionally waits for
// a vsync rising edge, then writes the fill colour one pixel per completed
// write on a wait-request write port.
module fb_rect_fill #(
  parameter int FB_W = fb_pkg::FB_W,
  parameter int FB_H = fb_pkg::FB_H,
  parameter int AW   = fb_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [8:0]    cmd_x,
  input  logic [7:0]    cmd_y,
  input  logic [8:0]    cmd_w,
  input  logic [7:0]    cmd_h,
  input  logic [15:0]   cmd_color,
  input  logic          cmd_vswait,
  input  logic          vsync,
  output logic [AW-1:0] oADDR,
  output logic [15:0]   oWDATA,
  output logic          oWRITE,
  output logic [1:0]    oBE,
  input  logic          iWAITREQ,
  output logic          busy,
  output logic          done
);

  import fb_pkg::*;

  localparam logic [8:0] W_LIM = 9'(FB_W);
  localparam logic [7:0] H_LIM = 8'(FB_H);

  state_t        state;
  logic          vsync_q;
  logic [8:0]    x_q;
  logic [8:0]    w_q;
  logic [7:0]    y_q;
  logic [7:0]    h_q;
  rgb565_t       color_q;
  logic          vswait_q;
  logic          is_empty;
  logic          vsync_rise;
  logic          load;
  logic          advance;
  logic          last;
  logic [AW-1:0] gen_addr;

  assign cmd_ready  = (state == IDLE);
  assign is_empty   = (x_q >= W_LIM) || (y_q >= H_LIM) || (w_q == '0) || (h_q == '0);
  assign vsync_rise = vsync & ~vsync_q;
  assign load       = (state == CLIP) && !is_empty;
  assign advance    = (state == FILL) && !iWAITREQ && !last;
  assign oADDR      = gen_addr;

  fb_addr_gen #(
    .FB_W(FB_W),
    .FB_H(FB_H),
    .AW  (AW)
  ) u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .advance(advance),
    .x      (x_q),
    .y      (y_q),
    .w      (w_q),
    .h      (h_q),
    .addr   (gen_addr),
    .last   (last)
  );

  // Command handshake, state sequencing and the registered write-port outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      vsync_q  <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      w_q      <= '0;
      h_q      <= '0;
      color_q  <= '0;
      vswait_q <= 1'b0;
      oWDATA   <= '0;
      oWRITE   <= 1'b0;
      oBE      <= 2'b00;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      vsync_q <= vsync;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            x_q      <= cmd_x;
            y_q      <= cmd_y;
            w_q      <= cmd_w;
            h_q      <= cmd_h;
            color_q  <= cmd_color;
            vswait_q <= cmd_vswait;
            busy     <= 1'b1;
            state    <= CLIP;
          end
        end
        CLIP: begin
          oWDATA <= color_q;
          if (is_empty) begin
            done  <= 1'b1;
            state <= DONE;
          end else if (vswait_q) begin
            state <= VSWAIT;
          end else begin
            oWRITE <= 1'b1;
            oBE    <= 2'b11;
            state  <= FILL;
          end
        end
        VSWAIT: begin
          if (vsync_rise) begin
            oWRITE <= 1'b1;
            oBE    <= 2'b11;
            state  <= FILL;
          end
        end
        FILL: begin
          if (!iWAITREQ && last) begin
            oWRITE <= 1'b0;
            oBE    <= 2'b00;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          oWRITE <= 1'b0;
          oBE    <= 2'b00;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
